neopixel_cmd_ctrl: RTL
======================

# neopixel_cmd_ctrl

Command sequencer between the input synchronizers and the NeoPixel pixel store and transmitter. It debounces the synchronized KEY0 push-button and decodes synchronized SW[4:0] into commands. Commands select a pixel and a colour channel, write a scaled intensity into the pixel store, or start a strip transmission. Transmission starts are handshaken against the transmitter's busy flag so that no frame is ever started while another is in flight.

## Interface
Parameters:
- NUM_PIXELS, 5: number of pixels in the store. Valid indices are 0..NUM_PIXELS-1, and NUM_PIXELS must be ≤ 8.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz). Must be ≥ 2.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- syncedKEY0, input, 1: synchronized KEY0. Active-low; 0 means pressed.
- syncedSW, input, 5: synchronized switches. [4:3] is the opcode and [2:0] is the argument.
- neo_busy, input, 1: high while the transmitter is shifting a frame.
- pix_wr, output, 1: one-cycle write strobe to the pixel store.
- pix_idx, output, 3: pixel index for the write. This is the current selection register.
- pix_chan, output, 2: channel for the write, where 0 is G, 1 is R and 2 is B. This is the current selection register.
- pix_data, output, 8: intensity for the write.
- send_start, output, 1: one-cycle pulse that starts a transmission.
- cmd_busy, output, 1: high in every state except IDLE.
- err, output, 1: one-cycle pulse when a command is rejected.

## Operation
- FSM states: IDLE, PRESS, EXEC, SEND_WAIT_BUSY, SEND_WAIT_DONE, RELEASE.
- **IDLE**
  - Debounce counter is held at 0.
  - syncedKEY0=0 → PRESS.
- **PRESS**
  - Counter increments each cycle that syncedKEY0=0.
  - syncedKEY0=1 → IDLE, counter cleared.
  - Counter reaches DEBOUNCE_CYCLES-1 with key still 0 → EXEC.
  - syncedSW is latched into cmd_reg on that same cycle.
- **EXEC** (exactly one cycle), decoding cmd_reg:
  - Opcode 00, SELECT_PIXEL:
    - arg < NUM_PIXELS → sel_idx ← arg.
    - Otherwise err pulses and sel_idx is unchanged.
    - Next state RELEASE.
  - Opcode 01, SELECT_CHAN:
    - arg[1:0] ≤ 2 → sel_chan ← arg[1:0].
    - arg[1:0] = 3 → err pulses.
    - arg[2] is ignored. Next state RELEASE.
  - Opcode 10, WRITE:
    - pix_wr=1 for one cycle.
    - pix_data = {arg, arg, arg[2:1]}, so 0→0x00, 4→0x92, 7→0xFF.
    - Next state RELEASE.
  - Opcode 11, SEND:
    - neo_busy=0 → send_start=1 for one cycle, then SEND_WAIT_BUSY.
    - neo_busy=1 → err pulses, then RELEASE.
- **SEND_WAIT_BUSY**
  - neo_busy=1 → SEND_WAIT_DONE.
- **SEND_WAIT_DONE**
  - neo_busy=0 → RELEASE.
- **RELEASE**
  - Counter increments each cycle that syncedKEY0=1.
  - syncedKEY0=0 clears the counter.
  - Reaching DEBOUNCE_CYCLES-1 → IDLE.
- Key activity in EXEC, SEND_WAIT_BUSY and SEND_WAIT_DONE is ignored. A press held through a send therefore never re-triggers; the key must be released and debounced first.
- The debounce counter is wide enough for DEBOUNCE_CYCLES-1 and never wraps. It saturates and is cleared on every state entry.
- pix_idx and pix_chan always drive sel_idx and sel_chan, which are valid outside write strobes. pix_data is 0 except during pix_wr.

## Timing
- Reset values: state=IDLE, counter=0, sel_idx=0, sel_chan=0, cmd_reg=0. All outputs are 0: pix_wr, pix_idx, pix_chan, pix_data, send_start, cmd_busy, err.
- Latency from the first cycle syncedKEY0=0 to the EXEC strobe (pix_wr, send_start or err) is DEBOUNCE_CYCLES+1 cycles, provided the key stays low.
- All strobes are registered and exactly one cycle wide. They are never asserted simultaneously.
- A selection update takes effect on pix_idx/pix_chan on the cycle after EXEC.
- neo_busy is sampled at the EXEC cycle. If it rises in that same cycle, the command is rejected.
- reset asserted mid-operation clears everything immediately, with no pending strobe. A send in flight is abandoned, and the transmitter is not told.
- After reset, a key held low is treated as a new press.

## Test plan
DEBOUNCE_CYCLES=4, NUM_PIXELS=5.
- Bounce rejection: KEY0 low 3 cycles, high, low 3 cycles, high → no strobe, err=0, state returns to IDLE.
- Write sequence:
  - SW=00_011, press; SW=01_001, press; SW=10_111, press.
  - Each press is KEY0 low 6 cycles, then high 6 cycles.
  - Required: one pix_wr with pix_idx=3, pix_chan=1, pix_data=0xFF. The strobe comes 5 cycles after the third press begins.
- Illegal args:
  - SW=00_110, press → err pulse, pix_idx stays 0.
  - SW=01_011, press → err pulse, pix_chan stays 0.
- Send handshake:
  - SW=11_000, press with neo_busy=0 → one send_start pulse.
  - Bench raises neo_busy 2 cycles later and holds it 20 cycles.
  - Required: cmd_busy=1 throughout, no second start even with KEY0 held low, IDLE only after neo_busy=0 and 4 high cycles.
- Busy rejection: SW=11_000, press with neo_busy=1 → err pulse, send_start=0.
- Reset mid-send: reset in SEND_WAIT_DONE → all outputs 0 and state IDLE that same cycle; sel_idx=0 and sel_chan=0.

Source files
------------

// File: rtl/neopixel_cmd_ctrl.sv
// neopixel_cmd_ctrl
// Command sequencer that sits between the input synchronizers and the
// NeoPixel pixel store and transmitter. It debounces KEY0, decodes SW[4:0]
// into select, write and send commands, and handshakes frame starts against
// the transmitter busy flag.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   syncedKEY0  synchronized KEY0, active-low (0 = pressed)
//   syncedSW    synchronized switches: [4:3] opcode, [2:0] argument
//   neo_busy    transmitter is shifting a frame
//   pix_wr      one-cycle write strobe to the pixel store
//   pix_idx     selected pixel index
//   pix_chan    selected channel (0 = G, 1 = R, 2 = B)
//   pix_data    write intensity, zero outside pix_wr
//   send_start  one-cycle transmission start pulse
//   cmd_busy    high whenever the sequencer is not idle
//   err         one-cycle pulse when a command is rejected
module neopixel_cmd_ctrl #(
  parameter int NUM_PIXELS      = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       syncedKEY0,
  input  logic [4:0] syncedSW,
  input  logic       neo_busy,
  output logic       pix_wr,
  output logic [2:0] pix_idx,
  output logic [1:0] pix_chan,
  output logic [7:0] pix_data,
  output logic       send_start,
  output logic       cmd_busy,
  output logic       err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  // The IDLE cycle that sees the first low sample counts as one stable
  // cycle, so PRESS leaves one count earlier than RELEASE does.
  localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    NUM_PIX    = 4'(NUM_PIXELS);

  localparam logic [1:0] OP_SEL_PIX  = 2'b00;
  localparam logic [1:0] OP_SEL_CHAN = 2'b01;
  localparam logic [1:0] OP_WRITE    = 2'b10;
  localparam logic [1:0] OP_SEND     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    EXEC,
    SEND_WAIT_BUSY,
    SEND_WAIT_DONE,
    RELEASE
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [4:0]    cmd_reg, cmd_next;
  logic [2:0]    sel_idx, sel_idx_next;
  logic [1:0]    sel_chan, sel_chan_next;
  logic          wr_q, wr_next;
  logic [7:0]    data_q, data_next;
  logic          start_q, start_next;
  logic          err_q, err_next;

  logic [1:0] opcode;
  logic [2:0] arg;

  assign opcode = cmd_reg[4:3];
  assign arg    = cmd_reg[2:0];

  // Saturating increment so the counter can never wrap.
  assign cnt_inc = (cnt == REL_LAST) ? cnt : cnt + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd_reg  <= '0;
      sel_idx  <= '0;
      sel_chan <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_next;
      cmd_reg  <= cmd_next;
      sel_idx  <= sel_idx_next;
      sel_chan <= sel_chan_next;
      wr_q     <= wr_next;
      data_q   <= data_next;
      start_q  <= start_next;
      err_q    <= err_next;
    end
  end

  // Next-state and strobe decode. Strobes are computed during EXEC and
  // registered, so they appear on the cycle after EXEC together with any
  // selection update. The counter is cleared on every state change.
  always_comb begin
    next_state    = state;
    cnt_next      = cnt;
    cmd_next      = cmd_reg;
    sel_idx_next  = sel_idx;
    sel_chan_next = sel_chan;
    wr_next       = 1'b0;
    data_next     = '0;
    start_next    = 1'b0;
    err_next      = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!syncedKEY0) next_state = PRESS;
      end

      PRESS: begin
        if (syncedKEY0) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == PRESS_LAST) begin
          next_state = EXEC;
          cnt_next   = '0;
          cmd_next   = syncedSW;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      EXEC: begin
        cnt_next   = '0;
        next_state = RELEASE;
        case (opcode)
          OP_SEL_PIX: begin
            if ({1'b0, arg} < NUM_PIX) sel_idx_next = arg;
            else                       err_next     = 1'b1;
          end
          OP_SEL_CHAN: begin
            if (arg[1:0] != 2'd3) sel_chan_next = arg[1:0];
            else                  err_next      = 1'b1;
          end
          OP_WRITE: begin
            wr_next   = 1'b1;
            data_next = {arg, arg, arg[2:1]};
          end
          OP_SEND: begin
            if (!neo_busy) begin
              start_next = 1'b1;
              next_state = SEND_WAIT_BUSY;
            end else begin
              err_next = 1'b1;
            end
          end
          default: next_state = RELEASE;
        endcase
      end

      SEND_WAIT_BUSY: begin
        cnt_next = '0;
        if (neo_busy) next_state = SEND_WAIT_DONE;
      end

      SEND_WAIT_DONE: begin
        cnt_next = '0;
        if (!neo_busy) next_state = RELEASE;
      end

      RELEASE: begin
        if (!syncedKEY0) begin
          cnt_next = '0;
        end else if (cnt == REL_LAST) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign pix_wr     = wr_q;
  assign pix_idx    = sel_idx;
  assign pix_chan   = sel_chan;
  assign pix_data   = data_q;
  assign send_start = start_q;
  assign err        = err_q;
  assign cmd_busy   = (state != IDLE);

endmodule
